// File: rtl/apb_slave_mem.sv
// APB3 slave backed by a DEPTH-word register memory with a fixed number of
// wait states per access and an error response for addresses beyond DEPTH.
module apb_slave_mem #(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int DEPTH       = 200,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic          pready,
  output logic [DW-1:0] prdata,
  output logic          pslverr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  // One extra bit so DEPTH == 2**AW is still representable.
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wcnt_q;
  logic [DW-1:0] mem [DEPTH];

  logic setup, in_range, complete, mem_we;

  assign setup    = (state_q == IDLE) && psel && !penable;
  assign in_range = {1'b0, addr_q} < DEPTH_L;
  assign pready   = (state_q == ACCESS) && (wcnt_q == 4'd0);
  assign complete = pready && psel && penable;
  assign mem_we   = complete && wr_q && in_range;
  assign prdata   = (pready && !wr_q && in_range) ? mem[addr_q] : '0;
  assign pslverr  = pready && !in_range;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d is given its hold value before the case so that no path
  // leaves it unassigned; otherwise a latch would be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS:  if (!psel || !penable || pready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is captured at the end of SETUP; bus changes during ACCESS are ignored.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      wcnt_q  <= 4'd0;
    end else if (setup) begin
      addr_q  <= paddr;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
      wcnt_q  <= WAIT_L;
    end else if (state_q == ACCESS && wcnt_q != 4'd0) begin
      wcnt_q  <= wcnt_q - 4'd1;
    end
  end

  // NOTE: the memory is built from flops rather than a RAM macro because every
  // word must clear asynchronously on reset; a macro could not do that.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter DW, default 8: data width (PWDATA/PRDATA).
REQ-002 SHALL have parameter AW, default 8: slave-local address width.
REQ-003 SHALL have parameter DEPTH, default 200: implemented words at addresses 0..DEPTH-1, with DEPTH <= 2**AW.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0: wait states inserted per access, range 0..15.
REQ-005 pclk  input  1  clock; all state updates on its rising edge.
REQ-006 presetn  input  1  reset; asynchronous, active-low.
REQ-007 psel  input  1  slave select from APB master.
REQ-008 penable  input  1  access-phase indicator.
REQ-009 pwrite  input  1  1=write, 0=read.
REQ-010 paddr  input  AW  word address.
REQ-011 pwdata  input  DW  write data.
REQ-012 pready  output  1  transfer complete.
REQ-013 prdata  output  DW  read data.
REQ-014 pslverr  output  1  transfer error, valid only while pready=1.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and ACCESS.
REQ-016 SETUP phase SHALL be a cycle in IDLE with psel=1 and penable=0.
REQ-017 At the rising edge ending a SETUP phase, the block SHALL:
  - latch paddr, pwrite and pwdata into addr_q, wr_q and wdata_q;
  - load wait counter wcnt with WAIT_CYCLES;
  - enter ACCESS.
REQ-018 In IDLE, psel=1 with penable=1 (no preceding SETUP) SHALL be ignored: stay IDLE, pready=0, no memory change.
REQ-019 In ACCESS, while wcnt!=0, wcnt SHALL decrement by 1 per cycle.
REQ-020 pready SHALL equal (state==ACCESS && wcnt==0), decoded from registers only with no input path.
REQ-021 Completion latency: pready=1 in ACCESS cycle number WAIT_CYCLES+1 (first ACCESS cycle when WAIT_CYCLES=0).
REQ-022 At the edge ending a cycle with pready=1, psel=1 and penable=1, the block SHALL:
  - write wdata_q to mem[addr_q] if wr_q=1 and addr_q<DEPTH;
  - return to IDLE.
REQ-023 Access-phase decisions SHALL use only latched values; paddr, pwrite and pwdata changes during ACCESS SHALL be ignored.
REQ-024 prdata SHALL equal mem[addr_q] when pready=1, wr_q=0 and addr_q<DEPTH, otherwise 0.
REQ-025 pslverr SHALL be 1 when pready=1 and addr_q>=DEPTH, otherwise 0; out-of-range writes SHALL NOT modify memory.
REQ-026 psel=0 or penable=0 in ACCESS SHALL abort the transfer: return to IDLE next edge, no write.
REQ-027 Back-to-back: a SETUP phase in the cycle after completion SHALL be accepted with no extra idle cycle.
REQ-028 A write followed by a read of the same address SHALL return the new data.

Reset
REQ-029 While presetn=0, the block SHALL:
  - force state to IDLE and wcnt to 0 immediately, independent of pclk;
  - clear addr_q, wr_q and wdata_q;
  - clear all memory words to 0.
REQ-030 While presetn=0, pready, prdata and pslverr SHALL be 0.
REQ-031 Reset mid-transfer SHALL discard the transfer with no memory write; the first SETUP after presetn rises SHALL be accepted normally.

Verification
REQ-032 WAIT_CYCLES=0: write 0xA5 to addr 0x10, then read 0x10 -> pready=1 in first ACCESS cycle each time, prdata=0xA5, pslverr=0.
REQ-033 WAIT_CYCLES=2: read addr 0x05 after reset -> pready low for 2 ACCESS cycles, high on the 3rd, prdata=0x00.
REQ-034 Write 0x3C to addr 200 (>=DEPTH) -> pready=1 with pslverr=1; a subsequent read of addr 200 -> pslverr=1, prdata=0.
REQ-035 Back-to-back write 0x11 to 0x01 then write 0x22 to 0x02 then reads -> no idle gap between transfers; reads return 0x11 and 0x22.
REQ-036 Write 0x77 to 0x20 with presetn pulsed low during the ACCESS wait (WAIT_CYCLES=3) -> outputs 0 immediately; a later read of 0x20 returns 0x00.
REQ-037 psel=1, penable=1 from IDLE with no SETUP -> pready stays 0 and memory is unchanged; psel deasserted in ACCESS -> abort, no write.
